debouncer_multi_repeat: RTL and testbench

//  N-channel push-button conditioner for the game controls. Replaces the single-channel delayed debouncer.
//  Per channel: 2-FF synchroniser, counter-based debounce, press/release strobes and auto-repeat (held key
//  re-fires moves). Sits between board buttons and the game FSM; all outputs are synchronous to clk.

---
 rtl/debouncer_multi_repeat_if.sv | 27 ++
 rtl/debouncer_multi_repeat.sv | 161 ++++++++++++++++
 tb/tb_debouncer_multi_repeat.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/debouncer_multi_repeat_if.sv
// Button bus between the board inputs and the game FSM.
// master drives raw buttons; slave returns conditioned events.
interface debouncer_multi_repeat_if #(
    parameter int CHANNELS = 5
);
    logic [CHANNELS-1:0] noisy_i;
    logic [CHANNELS-1:0] debounced_o;
    logic [CHANNELS-1:0] press_o;
    logic [CHANNELS-1:0] release_o;
    logic [CHANNELS-1:0] action_o;

    modport master (
        output noisy_i,
        input  debounced_o,
        input  press_o,
        input  release_o,
        input  action_o
    );

    modport slave (
        input  noisy_i,
        output debounced_o,
        output press_o,
        output release_o,
        output action_o
    );
endinterface

// File: rtl/debouncer_multi_repeat.sv
// N-channel button conditioner: 2-FF sync, counter debounce,
// press/release strobes and per-channel auto-repeat.
module debouncer_multi_repeat #(
    parameter int                  CHANNELS            = 5,
    parameter int                  DEBOUNCE_CYCLES     = 2_000_000,
    parameter int                  REPEAT_DELAY_CYCLES = 25_000_000,
    parameter int                  REPEAT_RATE_CYCLES  = 5_000_000,
    parameter logic [CHANNELS-1:0] REPEAT_EN           = {CHANNELS{1'b1}},
    parameter bit                  ACTIVE_LOW          = 1'b0
) (
    input logic                     clk,
    input logic                     reset_n,
    debouncer_multi_repeat_if.slave bus
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES)
                        ? REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY_CYCLES);
    localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE_CYCLES);
    localparam logic [RW-1:0] R_ONE   = RW'(1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } db_state_e;

    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] deb_v;
    logic [CHANNELS-1:0] press_v;
    logic [CHANNELS-1:0] rel_v;
    logic [CHANNELS-1:0] act_v;

    assign raw = ACTIVE_LOW ? ~bus.noisy_i : bus.noisy_i;

    // Two-stage synchroniser; reset value means "not pressed"
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        db_state_e     state_q, state_d;
        logic [DW-1:0] cnt_q, cnt_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          s;
        logic          deb_q;
        logic          press_d, rel_d, rep_d;
        logic          press_q, rel_q, act_q;

        assign s     = sync2_q[i];
        assign deb_q = (state_q == STABLE_HI) || (state_q == WAIT_LO);

        // Debounce FSM: a change must hold DEBOUNCE_CYCLES to be accepted
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            unique case (state_q)
                STABLE_LO: begin
                    cnt_d = '0;
                    if (s) begin
                        state_d = WAIT_HI;
                        cnt_d   = DB_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_MAX) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DB_ONE;
                    end
                end
                STABLE_HI: begin
                    cnt_d = '0;
                    if (!s) begin
                        state_d = WAIT_LO;
                        cnt_d   = DB_ONE;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_MAX) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DB_ONE;
                    end
                end
            endcase
        end

        // Repeat down-counter: loaded at press, fires on reaching 1
        always_comb begin
            rcnt_d = rcnt_q;
            rep_d  = 1'b0;
            if (!REPEAT_EN[i]) begin
                rcnt_d = '0;
            end else if (press_d) begin
                rcnt_d = R_DELAY;
            end else if (!deb_q || rel_d) begin
                rcnt_d = '0;
            end else if (rcnt_q == R_ONE) begin
                rep_d  = 1'b1;
                rcnt_d = R_RATE;
            end else begin
                rcnt_d = rcnt_q - R_ONE;
            end
        end

        // Channel state and registered strobes
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                rcnt_q  <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                act_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rcnt_q  <= rcnt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                act_q   <= press_d | rep_d;
            end
        end

        assign deb_v[i]   = deb_q;
        assign press_v[i] = press_q;
        assign rel_v[i]   = rel_q;
        assign act_v[i]   = act_q;
    end

    assign bus.debounced_o = deb_v;
    assign bus.press_o     = press_v;
    assign bus.release_o   = rel_v;
    assign bus.action_o    = act_v;
endmodule

// File: tb/tb_debouncer_multi_repeat.sv
// Directed bench: DEBOUNCE=4, DELAY=10, RATE=3, three channels.
// dut_a repeats on all channels, dut_b has ch0 repeat disabled.
module tb_debouncer_multi_repeat;
    localparam int CH = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    debouncer_multi_repeat_if #(.CHANNELS(CH)) bus_a ();
    debouncer_multi_repeat_if #(.CHANNELS(CH)) bus_b ();

    debouncer_multi_repeat #(
        .CHANNELS(CH),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY_CYCLES(10),
        .REPEAT_RATE_CYCLES(3),
        .REPEAT_EN(3'b111),
        .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_a)
    );

    debouncer_multi_repeat #(
        .CHANNELS(CH),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY_CYCLES(10),
        .REPEAT_RATE_CYCLES(3),
        .REPEAT_EN(3'b110),
        .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] fa(int c);
        return {bus_a.debounced_o[c], bus_a.press_o[c],
                bus_a.release_o[c], bus_a.action_o[c]};
    endfunction

    function automatic logic [3:0] fb(int c);
        return {bus_b.debounced_o[c], bus_b.press_o[c],
                bus_b.release_o[c], bus_b.action_o[c]};
    endfunction

    function automatic logic [11:0] all_a();
        return {bus_a.debounced_o, bus_a.press_o,
                bus_a.release_o, bus_a.action_o};
    endfunction

    function automatic logic [11:0] all_b();
        return {bus_b.debounced_o, bus_b.press_o,
                bus_b.release_o, bus_b.action_o};
    endfunction

    task automatic test_reset();
        logic [11:0] got;
        bus_a.noisy_i = '0;
        bus_b.noisy_i = '0;
        #2 reset_n = 1'b0;
        #1;
        got = all_a();
        total_cnt++;
        if (got !== 12'h000)
            $display("FAIL reset_a got %h exp 000", got);
        else pass_cnt++;
        got = all_b();
        total_cnt++;
        if (got !== 12'h000)
            $display("FAIL reset_b got %h exp 000", got);
        else pass_cnt++;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            got = all_a();
            total_cnt++;
            if (got !== 12'h000)
                $display("FAIL idle k=%0d got %h exp 000", k, got);
            else pass_cnt++;
        end
    endtask

    task automatic test_press();
        logic [3:0] got, exp;
        bus_a.noisy_i[0] = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            got = fa(0);
            exp = {k >= 6, k == 6, 1'b0, k == 6};
            total_cnt++;
            if (got !== exp)
                $display("FAIL press k=%0d got %b exp %b",
                         k, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_repeat();
        logic [3:0] got, exp;
        logic       act;
        for (int k = 13; k <= 45; k++) begin
            tick();
            act = (k >= 16) && (k <= 34) && ((k - 16) % 3 == 0);
            exp = {k <= 35, 1'b0, k == 36, act};
            got = fa(0);
            total_cnt++;
            if (got !== exp)
                $display("FAIL repeat k=%0d got %b exp %b",
                         k, got, exp);
            else pass_cnt++;
            if (k == 29) bus_a.noisy_i[0] = 1'b0;
        end
    endtask

    task automatic test_glitch();
        logic [3:0] got;
        bus_a.noisy_i[1] = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            tick();
            if (k == 2) bus_a.noisy_i[1] = 1'b0;
            got = fa(1);
            total_cnt++;
            if (got !== 4'b0000)
                $display("FAIL glitch k=%0d got %b exp 0000",
                         k, got);
            else pass_cnt++;
        end
    endtask

    task automatic test_chatter();
        logic [3:0] got, exp;
        for (int k = 0; k <= 40; k++) begin
            if (k < 20) bus_a.noisy_i[2] = ((k / 2) % 2 == 0);
            else        bus_a.noisy_i[2] = (k <= 30);
            tick();
            exp = {(k >= 26) && (k <= 36), k == 26, k == 37,
                   (k == 26) || (k == 36)};
            got = fa(2);
            total_cnt++;
            if (got !== exp)
                $display("FAIL chatter k=%0d got %b exp %b",
                         k, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  got, exp;
        logic [11:0] all;
        bus_a.noisy_i[0] = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            if (k == 16) begin
                got = fa(0);
                total_cnt++;
                if (got !== 4'b1001)
                    $display("FAIL pre_rst got %b exp 1001", got);
                else pass_cnt++;
            end
        end
        reset_n = 1'b0;
        #1;
        all = all_a();
        total_cnt++;
        if (all !== 12'h000)
            $display("FAIL rst_now got %h exp 000", all);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            tick();
            all = all_a();
            total_cnt++;
            if (all !== 12'h000)
                $display("FAIL rst_hold k=%0d got %h exp 000",
                         k, all);
            else pass_cnt++;
        end
        reset_n = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            got = fa(0);
            exp = {k >= 6, k == 6, 1'b0, k == 6};
            total_cnt++;
            if (got !== exp)
                $display("FAIL rst_repress k=%0d got %b exp %b",
                         k, got, exp);
            else pass_cnt++;
        end
        bus_a.noisy_i[0] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_repeat_en();
        logic [3:0] got;
        int         n_act;
        n_act = 0;
        for (int k = 0; k <= 50; k++) begin
            bus_b.noisy_i[0] = (k < 40);
            tick();
            got = fb(0);
            if (got[0]) n_act++;
            if (k == 6) begin
                total_cnt++;
                if (got !== 4'b1101)
                    $display("FAIL noreps_press got %b exp 1101", got);
                else pass_cnt++;
            end
            if (k == 46) begin
                total_cnt++;
                if (got !== 4'b0010)
                    $display("FAIL noreps_rel got %b exp 0010", got);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (n_act !== 1)
            $display("FAIL noreps_count got %0d exp 1", n_act);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp;
        bus_b.noisy_i[2:1] = 2'b11;
        for (int k = 0; k <= 9; k++) begin
            tick();
            exp = (k == 6) ? 2'b11 : 2'b00;
            total_cnt++;
            if (bus_b.press_o[2:1] !== exp)
                $display("FAIL simul_press k=%0d got %b exp %b",
                         k, bus_b.press_o[2:1], exp);
            else pass_cnt++;
            total_cnt++;
            if (bus_b.action_o[2:1] !== exp)
                $display("FAIL simul_act k=%0d got %b exp %b",
                         k, bus_b.action_o[2:1], exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_repeat();
        test_glitch();
        test_chatter();
        test_reset_mid();
        test_repeat_en();
        test_simultaneous();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
